// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main controller.
// Holds the opcodes, the 4-bit FSM state encodings, the ALUOp codes (also used
// by the ALU controller), the ALUSrcB / PCSource mux encodings and the bundled
// control-word type produced by the output decoder.
package mc_ctrl_pkg;

    // Opcodes handled by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes driven towards the ALU controller
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_SLTIEX = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_SLTI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control-word decoder for the multi-cycle controller.
// Ports:
//   state     - current FSM state
//   op        - opcode from the instruction register (used for illegal detect)
//   mem_ready - memory handshake (FETCH enables, MEMWR completion)
//   ctrl      - full control word; fields not set for a state stay 0
module mc_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR load and PC+4 commit only on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = ~op_is_legal(op);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_SLTIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_SLT;
            end
            S_IWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Holds the state register and next-state logic; the control word comes from
// mc_out_decode. All outputs (including state_o) are forced to 0 while rst_i
// is high so a reset mid-instruction cannot leave a partial write behind.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   op_i              - opcode, stable from DECODE to the next FETCH
//   mem_ready_i       - memory access completes this cycle
//   *_o control       - datapath enables and mux selects
//   instr_done_o      - last cycle of a retired instruction
//   illegal_o         - unsupported opcode seen in DECODE
//   state_o           - current state (debug)
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       MemtoReg_o,
    output logic       RegDst_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_SLTI:      state_d = S_SLTIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but lw is a store
            S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_IWB;
            S_SLTIEX: state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_out_decode u_out_decode (
        .state     (state_q),
        .op        (op_i),
        .mem_ready (mem_ready_i),
        .ctrl      (ctrl)
    );

    // Reset masks the whole control word, not just the write enables
    assign ctrl_g = rst_i ? '0 : ctrl;

    assign PCWrite_o     = ctrl_g.pc_write;
    assign PCWriteCond_o = ctrl_g.pc_write_cond;
    assign IorD_o        = ctrl_g.iord;
    assign MemRead_o     = ctrl_g.mem_read;
    assign MemWrite_o    = ctrl_g.mem_write;
    assign IRWrite_o     = ctrl_g.ir_write;
    assign MemtoReg_o    = ctrl_g.mem_to_reg;
    assign RegDst_o      = ctrl_g.reg_dst;
    assign RegWrite_o    = ctrl_g.reg_write;
    assign ALUSrcA_o     = ctrl_g.alu_src_a;
    assign ALUSrcB_o     = ctrl_g.alu_src_b;
    assign ALUOp_o       = ctrl_g.alu_op;
    assign PCSource_o    = ctrl_g.pc_source;
    assign instr_done_o  = ctrl_g.instr_done;
    assign illegal_o     = ctrl_g.illegal;
    assign state_o       = rst_i ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction pushes its per-cycle
// stimulus and expected state/control word; the drive loop pops, applies and
// compares every cycle, and also checks instruction length between done pulses.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SLTI = 6'b001010;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done, illegal;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_i          (op),
        .mem_ready_i   (mem_ready),
        .PCWrite_o     (pc_write),
        .PCWriteCond_o (pc_write_cond),
        .IorD_o        (iord),
        .MemRead_o     (mem_read),
        .MemWrite_o    (mem_write),
        .IRWrite_o     (ir_write),
        .MemtoReg_o    (mem_to_reg),
        .RegDst_o      (reg_dst),
        .RegWrite_o    (reg_write),
        .ALUSrcA_o     (alu_src_a),
        .ALUSrcB_o     (alu_src_b),
        .ALUOp_o       (alu_op),
        .PCSource_o    (pc_source),
        .instr_done_o  (instr_done),
        .illegal_o     (illegal),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [18:0] vec;
        int          len;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected control word, packed as
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0],done,illegal}
    function automatic logic [18:0] exp_vec(input int st, input logic rdy, input logic ill);
        logic pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, dn, il;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, dn, il} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin io = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin io = 1; mwr = 1; dn = rdy; end
            6:  begin sa = 1; ao = 3'b010; end
            7:  begin rd = 1; rw = 1; dn = 1; end
            8:  begin sa = 1; ao = 3'b001; pcwc = 1; ps = 2'b01; dn = 1; end
            9:  begin pcw = 1; ps = 2'b10; dn = 1; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin sa = 1; sb = 2'b10; ao = 3'b011; end
            12: begin rw = 1; dn = 1; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, dn, il};
    endfunction

    task automatic push(input logic r, input logic rdy, input logic [5:0] o,
                        input int st, input logic ill, input int len);
        ent_t e;
        e.rst = r;
        e.rdy = rdy;
        e.op  = o;
        e.st  = r ? 4'd0 : 4'(st);
        e.vec = r ? 19'd0 : exp_vec(st, rdy, ill);
        e.len = len;
        q.push_back(e);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // fw = fetch wait cycles, mw = memory wait cycles (lw/sw only)
    task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
        int   len;
        logic ill;
        ill = !(o inside {T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_SLTI, T_J});
        case (o)
            T_LW:                   len = 5 + mw;
            T_SW:                   len = 4 + mw;
            T_R, T_ADDI, T_SLTI:    len = 4;
            T_BEQ, T_J:             len = 3;
            default:                len = 0;
        endcase
        if (len != 0) len += fw;
        for (int i = 0; i < fw; i++) push(0, 0, o, 0, ill, len);
        push(0, 1, o, 0, ill, len);
        push(0, rnd_bit(), o, 1, ill, len);
        case (o)
            T_LW: begin
                push(0, rnd_bit(), o, 2, ill, len);
                for (int i = 0; i < mw; i++) push(0, 0, o, 3, ill, len);
                push(0, 1, o, 3, ill, len);
                push(0, rnd_bit(), o, 4, ill, len);
            end
            T_SW: begin
                push(0, rnd_bit(), o, 2, ill, len);
                for (int i = 0; i < mw; i++) push(0, 0, o, 5, ill, len);
                push(0, 1, o, 5, ill, len);
            end
            T_R: begin
                push(0, rnd_bit(), o, 6, ill, len);
                push(0, rnd_bit(), o, 7, ill, len);
            end
            T_BEQ:  push(0, rnd_bit(), o, 8, ill, len);
            T_J:    push(0, rnd_bit(), o, 9, ill, len);
            T_ADDI: begin
                push(0, rnd_bit(), o, 10, ill, len);
                push(0, rnd_bit(), o, 12, ill, len);
            end
            T_SLTI: begin
                push(0, rnd_bit(), o, 11, ill, len);
                push(0, rnd_bit(), o, 12, ill, len);
            end
            default: ;
        endcase
    endtask

    // lw abandoned by a reset while waiting in MEMRD
    task automatic lw_reset_in_memrd();
        push(0, 1, T_LW, 0, 0, 0);
        push(0, 0, T_LW, 1, 0, 0);
        push(0, 0, T_LW, 2, 0, 0);
        push(0, 0, T_LW, 3, 0, 0);
        push(0, 0, T_LW, 3, 0, 0);
        push(1, 1, T_LW, 0, 0, 0);
    endtask

    task automatic drain();
        ent_t        e;
        logic [18:0] got;
        int          cyc;
        cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            rst       = e.rst;
            mem_ready = e.rdy;
            op        = e.op;
            @(negedge clk);
            got = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, instr_done, illegal};
            chk("state", 32'(state), 32'(e.st));
            chk("ctrl", 32'(got), 32'(e.vec));
            if (e.rst) begin
                cyc = 0;
            end else begin
                cyc++;
                if (instr_done) begin
                    chk("len", 32'(cyc), 32'(e.len));
                    cyc = 0;
                end
                if (illegal) cyc = 0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_SLTI, T_J, T_BAD};
        rst = 1'b1;
        op = 6'd0;
        mem_ready = 1'b0;

        push(1, 0, 6'd0, 0, 0, 0);
        push(1, 1, 6'd0, 0, 0, 0);
        run_instr(T_LW, 0, 0);
        run_instr(T_SW, 0, 3);
        run_instr(T_R, 0, 0);
        run_instr(T_BEQ, 0, 0);
        run_instr(T_ADDI, 0, 0);
        run_instr(T_SLTI, 0, 0);
        run_instr(T_J, 0, 0);
        run_instr(T_BAD, 0, 0);
        run_instr(T_LW, 2, 1);
        lw_reset_in_memrd();
        run_instr(T_R, 0, 0);
        for (int i = 0; i < 10; i++)
            run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
